// File: rtl/obstacle_pkg.sv
// Shared constants and types for the obstacle lane generator.
package obstacle_pkg;

    localparam int          LFSR_W        = 16;
    localparam logic [15:0] LFSR_MASK     = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;
    localparam int          LANE_W        = 8;

    typedef logic [LANE_W-1:0] lane_t;

    // One Galois step of the x^16+x^14+x^13+x^11+1 generator.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] cur);
        logic [LFSR_W-1:0] nxt;
        nxt = cur >> 1;
        if (cur[0]) begin
            nxt = nxt ^ LFSR_MASK;
        end else begin
            nxt = nxt;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/obstacle_lfsr.sv
// Free-running 16-bit Galois LFSR, advanced once per enabled cycle.
module obstacle_lfsr
    import obstacle_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = LFSR_SEED_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic [LFSR_W-1:0] value
);

    logic [LFSR_W-1:0] lfsr_r;

    // Seed on reset, advance on each enabled step, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_r <= SEED;
        end else if (en) begin
            lfsr_r <= lfsr_step(lfsr_r);
        end else begin
            lfsr_r <= lfsr_r;
        end
    end

    assign value = lfsr_r;

endmodule

// File: rtl/obstacle_gen.sv
// Obstacle lane generator: scrolls an occupancy register one column per
// game tick, inserting a new column whose obstacle bit is random but
// constrained by minimum and maximum gap rules.
module obstacle_gen
    import obstacle_pkg::*;
#(
    parameter int          WIDTH     = LANE_W,
    parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEF,
    parameter int          MIN_GAP   = 2,
    parameter int          MAX_GAP   = 6,
    parameter logic [8:0]  THRESH    = 9'd64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    output logic [WIDTH-1:0] down
);

    // Gap counter must hold 0..MAX_GAP; keep at least one bit.
    localparam int          GW    = (MAX_GAP < 1) ? 1 : $clog2(MAX_GAP + 1);
    localparam logic [31:0] MIN_U = 32'(MIN_GAP);
    localparam logic [31:0] MAX_U = 32'(MAX_GAP);

    logic [LFSR_W-1:0] lfsr_s;
    logic [GW-1:0]     gap_cnt_r;
    logic [31:0]       gap_ext_s;
    logic              rnd_hit_s;
    logic              spawn_s;
    logic [GW-1:0]     gap_next_s;

    obstacle_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (reset),
        .en    (tick),
        .value (lfsr_s)
    );

    assign gap_ext_s = {{(32-GW){1'b0}}, gap_cnt_r};
    assign rnd_hit_s = ({1'b0, lfsr_s[7:0]} < THRESH);

    // Spawn decision from pre-advance state; min-gap wins over max-gap.
    always_comb begin
        spawn_s = 1'b0;
        if (gap_ext_s < MIN_U) begin
            spawn_s = 1'b0;
        end else if (gap_ext_s >= MAX_U) begin
            spawn_s = 1'b1;
        end else begin
            spawn_s = rnd_hit_s;
        end
    end

    // Next gap count: clear on spawn, else count up saturating at MAX_GAP.
    always_comb begin
        gap_next_s = gap_cnt_r;
        if (spawn_s) begin
            gap_next_s = {GW{1'b0}};
        end else if (gap_ext_s >= MAX_U) begin
            gap_next_s = MAX_U[GW-1:0];
        end else begin
            gap_next_s = gap_cnt_r + GW'(1);
        end
    end

    // Lane shift register and gap counter, updated once per tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            down      <= {WIDTH{1'b0}};
            gap_cnt_r <= {GW{1'b0}};
        end else if (tick) begin
            down      <= {spawn_s, down[WIDTH-1:1]};
            gap_cnt_r <= gap_next_s;
        end else begin
            down      <= down;
            gap_cnt_r <= gap_cnt_r;
        end
    end

endmodule

// File: tb/tb_obstacle_gen.sv
// Self-checking bench for obstacle_gen: three instances (THRESH 256, 0,
// default 64) share clock, reset and tick, and are compared against a
// behavioural model of the spawn stream.
module tb_obstacle_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic [7:0] down_a;
    logic [7:0] down_b;
    logic [7:0] down_c;

    always #5 clk = ~clk;

    obstacle_gen #(.THRESH(9'd256)) d_all  (.clk(clk), .reset(reset), .tick(tick), .down(down_a));
    obstacle_gen #(.THRESH(9'd0))   d_none (.clk(clk), .reset(reset), .tick(tick), .down(down_b));
    obstacle_gen                    d_def  (.clk(clk), .reset(reset), .tick(tick), .down(down_c));

    int nvec = 0;
    int nerr = 0;

    // Behavioural model: one entry per instance.
    int         thr   [3] = '{256, 0, 64};
    int         m_lfsr[3];
    int         m_run [3];
    int         m_down[3];

    typedef struct {
        int         n;
        int         sel;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int get_down(input int i);
        case (i)
            0:       return int'(down_a);
            1:       return int'(down_b);
            default: return int'(down_c);
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_lfsr[i] = 'hACE1;
            m_run[i]  = 0;
            m_down[i] = 0;
        end
    endtask

    // Spawn rule stated directly: at least 2 zeros before a one, a one
    // forced once 6 zeros have passed, otherwise low LFSR byte < THRESH.
    task automatic model_step();
        int sp;
        for (int i = 0; i < 3; i++) begin
            if (m_run[i] < 2)       sp = 0;
            else if (m_run[i] >= 6) sp = 1;
            else                    sp = ((m_lfsr[i] % 256) < thr[i]) ? 1 : 0;
            m_down[i] = (m_down[i] / 2) + sp * 128;
            m_run[i]  = sp ? 0 : m_run[i] + 1;
            m_lfsr[i] = (m_lfsr[i] / 2) ^ ((m_lfsr[i] % 2) ? 'hB400 : 0);
        end
    endtask

    task automatic check_all(input string name);
        for (int i = 0; i < 3; i++) begin
            chk(name, get_down(i), m_down[i]);
        end
    endtask

    // One clock with the given tick level; outputs sampled 1 time unit later.
    task automatic cyc(input logic t);
        tick = t;
        @(posedge clk);
        #1;
        if (t) model_step();
    endtask

    task automatic do_reset();
        tick  = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
    endtask

    int          count;
    int          ticks;
    int          zeros;
    bit          seen_one;
    logic [7:0]  hold_down;
    logic [15:0] hold_lfsr;
    logic        sched[200];
    logic [7:0]  rec  [200];

    initial begin
        tick  = 1'b0;
        reset = 1'b0;
        model_reset();

        // Reset held with tick toggling: all lanes stay empty.
        for (int k = 0; k < 6; k++) begin
            tick = logic'(k % 2);
            @(posedge clk);
            #1;
            chk("reset_hold_a", down_a, 0);
            chk("reset_hold_b", down_b, 0);
            chk("reset_hold_c", down_c, 0);
        end
        tick  = 1'b0;
        reset = 1'b1;
        model_reset();

        // Table of expected lanes after N single-cycle tick pulses.
        tbl[0] = '{n: 3,  sel: 0, exp: 8'b1000_0000};
        tbl[1] = '{n: 6,  sel: 0, exp: 8'b1001_0000};
        tbl[2] = '{n: 6,  sel: 1, exp: 8'b0000_0000};
        tbl[3] = '{n: 7,  sel: 1, exp: 8'b1000_0000};
        tbl[4] = '{n: 8,  sel: 1, exp: 8'b0100_0000};
        tbl[5] = '{n: 9,  sel: 0, exp: 8'b1001_0010};
        tbl[6] = '{n: 12, sel: 0, exp: 8'b1001_0010};
        tbl[7] = '{n: 14, sel: 1, exp: 8'b1000_0001};
        count = 0;
        for (int k = 0; k < 8; k++) begin
            while (count < tbl[k].n) begin
                cyc(1'b1);
                cyc(1'b0);
                count++;
            end
            chk($sformatf("table_%0d", k), get_down(tbl[k].sel), int'(tbl[k].exp));
        end
        check_all("table_model");

        // Asynchronous reset mid-run clears lanes before any clock edge.
        #3;
        reset = 1'b0;
        #1;
        chk("async_rst_a", down_a, 0);
        chk("async_rst_b", down_b, 0);
        chk("async_rst_c", down_c, 0);
        #1;
        reset = 1'b1;
        model_reset();

        // Advance a little, then idle 100 cycles: nothing may move.
        for (int k = 0; k < 9; k++) cyc(1'b1);
        check_all("pre_idle");
        hold_down = down_c;
        hold_lfsr = d_def.u_lfsr.value;
        for (int k = 0; k < 100; k++) cyc(1'b0);
        chk("idle_down", down_c, hold_down);
        chk("idle_lfsr", d_def.u_lfsr.value, hold_lfsr);
        check_all("idle_model");

        // Tick held high for 5 cycles: exactly 5 steps.
        for (int k = 0; k < 5; k++) begin
            cyc(1'b1);
            check_all("held_tick");
        end
        cyc(1'b0);
        check_all("held_tick_end");

        // Randomized run of 1000 ticks against the model plus gap invariants.
        do_reset();
        ticks    = 0;
        zeros    = 0;
        seen_one = 1'b0;
        for (int c = 0; c < 5000 && ticks < 1000; c++) begin
            logic t;
            t = logic'($urandom_range(0, 1));
            cyc(t);
            check_all("random");
            chk("lfsr_model", d_def.u_lfsr.value, m_lfsr[2]);
            chk("lfsr_nonzero", (d_def.u_lfsr.value != 16'h0000) ? 1 : 0, 1);
            if (t) begin
                ticks++;
                if (down_c[7]) begin
                    if (seen_one) chk("gap_range", (zeros >= 2 && zeros <= 6) ? 1 : 0, 1);
                    else          chk("first_gap", (zeros >= 2 && zeros <= 6) ? 1 : 0, 1);
                    zeros    = 0;
                    seen_one = 1'b1;
                end else begin
                    zeros++;
                    chk("max_zero_run", (zeros <= 6) ? 1 : 0, 1);
                end
            end
        end
        chk("random_ticks_done", ticks, 1000);

        // Two resets with the same tick schedule give identical lanes.
        for (int k = 0; k < 200; k++) sched[k] = logic'($urandom_range(0, 1));
        do_reset();
        for (int k = 0; k < 200; k++) begin
            cyc(sched[k]);
            rec[k] = down_c;
        end
        do_reset();
        for (int k = 0; k < 200; k++) begin
            cyc(sched[k]);
            chk("replay", down_c, rec[k]);
        end
        check_all("replay_model");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/obstacle_gen.md
Name: obstacle_gen

Overview:
- Obstacle lane generator for the dino runner game.
- Holds an 8-column occupancy shift register, `down`. On each game `tick` the register scrolls one column toward the player and a new column enters at the far end.
- The new column's obstacle bit comes from a free-running 16-bit LFSR, gated by minimum-gap and maximum-gap rules so the course is always jumpable and never empty for long.
- Sits between the game tick divider and the collision/render logic.

Parameters:
- WIDTH, 8: number of lane columns (width of `down`).
- LFSR_SEED, 16'hACE1: LFSR value loaded at reset; must be non-zero.
- MIN_GAP, 2: minimum number of empty columns between two obstacles.
- MAX_GAP, 6: after this many consecutive empty columns an obstacle is forced.
- THRESH, 64: spawn probability numerator over 256, 9-bit, range 0..256. 0 means only forced spawns; 256 means spawn whenever allowed.

Ports:
- clk, input, 1: system clock, rising-edge active.
- reset, input, 1: asynchronous, active-low reset.
- tick, input, 1: game-step strobe; one step per clock cycle in which it is high.
- down, output, WIDTH: obstacle occupancy. Bit WIDTH-1 is the entry column; bit 0 is the column at the player.

Behaviour:
- One clock; reset is asynchronous and active-low (clk, reset).
- Reset (reset=0) immediately forces:
  - down = 0
  - lfsr = LFSR_SEED
  - gap_cnt = 0
- Reset may assert mid-operation; the state clears without waiting for a clock edge.
- All state updates on the rising edge of clk, only when reset=1 and tick=1. With tick=0 all state holds.
- `tick` is level-sampled. If it is held high for N cycles, N steps occur. No edge detection.
- LFSR:
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1, mask 16'hB400.
  - Advances exactly once per step.
  - Update: lfsr_next = (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 0).
- Spawn decision, per step, using the current (pre-advance) values:
  - rnd_hit = ({1'b0, lfsr[7:0]} < THRESH).
  - If gap_cnt < MIN_GAP: spawn = 0.
  - Else if gap_cnt >= MAX_GAP: spawn = 1.
  - Else: spawn = rnd_hit.
  - The min-gap rule takes priority if MIN_GAP > MAX_GAP is misconfigured.
- Shift, per step: down <= {spawn, down[WIDTH-1:1]}. The old bit 0 is discarded.
- gap_cnt, per step: cleared to 0 if spawn=1, else incremented, saturating at MAX_GAP. Width is clog2(MAX_GAP+1).
- Timing:
  - Latency: `down` reflects a step on the clock edge where tick is sampled high, visible the following cycle.
  - No combinational path from tick to down.
- Start-up guarantee: the first MIN_GAP steps after reset always insert 0 (gap_cnt starts at 0).
- Invariants:
  - Any two 1s in the spawn stream are separated by at least MIN_GAP 0s.
  - No run of 0s is longer than MAX_GAP.

Decomposition:
- Shared package obstacle_pkg holds:
  - the LFSR width and mask constants (16, 16'hB400);
  - the default seed;
  - a typedef for the lane vector (logic [WIDTH-1:0]).
- One sub-module, obstacle_lfsr: enable, seed load on reset, outputs the current value.
- The gap counter, spawn logic and shift register stay in obstacle_gen.

Test Plan:
- Hold reset=0, toggle tick, then release reset -> down=8'h00 throughout reset. Asserting reset asynchronously mid-run clears down to 8'h00 without a clock edge.
- THRESH=256, MIN_GAP=2, MAX_GAP=6, one-cycle tick pulses from reset -> down after 3/6/9/12 ticks = 8'b1000_0000, 8'b1001_0000, 8'b1001_0010, 8'b1001_0010. The spawn stream repeats 0,0,1.
- THRESH=0, MAX_GAP=6 -> first obstacle on tick 7 (down=8'b1000_0000). After 14 ticks down=8'b1000_0001. Never more than 6 consecutive 0s.
- tick=0 for 100 cycles mid-run -> down and the internal lfsr unchanged. Then tick held high for 5 cycles -> exactly 5 shifts.
- Default parameters, 1000 ticks with a scoreboard modelling the LFSR and spawn rule -> down matches the model every step. Checks also hold:
  - every inter-obstacle gap is within [MIN_GAP, MAX_GAP];
  - lfsr is never 0.
- Two resets with an identical tick schedule -> identical down sequences (deterministic seed).
